branch_resolve: RTL
===================

Name: branch_resolve

Overview:
- Stage directly downstream of the 32-bit ALU.
- Consumes the ALU result, the zero output and the registered N/Z/V status flags, plus per-instruction branch info from decode.
- Resolves the branch condition, computes the next PC, and produces the link-register write for "and-link" branches.
- Registered, one-entry valid/ready stage; squashes the single wrong-path beat after a taken branch.

Parameters:
- WIDTH, 32, datapath/PC width
- LINK_REG, 31, register index written by link branches

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- br_op  in  4  branch opcode (encoding below)
- alu_sum  in  WIDTH  ALU result
- alu_zout  in  1  ALU zero output
- status_n  in  1  registered ALU N flag
- status_z  in  1  registered ALU Z flag
- status_v  in  1  registered ALU V flag
- pc_plus4  in  WIDTH  PC of the instruction plus 4
- br_offset  in  WIDTH  sign-extended word offset
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- pc_next  out  WIDTH  resolved next PC
- taken  out  1  branch taken
- link_we  out  1  link write enable
- link_addr  out  5  link register index (= LINK_REG)
- link_data  out  WIDTH  link value (= pc_plus4)
- flush  out  1  one-cycle wrong-path kill pulse

Behaviour:
- br_op encodings:
  - 0000 none: not taken.
  - 0001 beq: taken when alu_zout.
  - 0010 bne: taken when !alu_zout.
  - 0011 blez: taken when status_n | status_z.
  - 0100 bgtz: taken when !status_n & !status_z.
  - 0101 bvs: taken when status_v.
  - 0110 brv: always taken; target = alu_sum with bits [1:0] forced to 0.
  - 0111 blezal: blez condition; link_we=1 only when taken.
  - 1000 bal: always taken, link_we=1.
  - All other codes behave as none.
- Relative target = pc_plus4 + (br_offset << 2), modulo 2^WIDTH (wraps silently).
- Not taken: pc_next = pc_plus4, link_we=0.
- Condition is evaluated on the input values present in the accept cycle (in_valid & in_ready). Latency 1: the result is registered and out_valid rises the next cycle.
- FSM states: IDLE, VALID, SQUASH.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept -> VALID.
- VALID:
  - out_valid=1; outputs held stable until out_ready.
  - in_ready = out_ready.
  - On out_ready & taken -> SQUASH. Any beat accepted in that same cycle is discarded.
  - On out_ready & !taken: new accept -> VALID, no accept -> IDLE.
  - While out_ready=0, outputs remain unchanged.
- SQUASH:
  - out_valid=0, in_ready=1.
  - The first accepted beat is dropped and the state returns to IDLE. With no beat, the state stays SQUASH.
- flush = 1 for exactly the cycle where out_valid & out_ready & taken.
- link_we and taken are meaningful only while out_valid=1 and are forced to 0 otherwise.
- Reset (asynchronous, any state, including mid-handshake):
  - state=IDLE.
  - out_valid=0, taken=0, link_we=0, flush=0.
  - pc_next=0, link_data=0, link_addr=LINK_REG.
  - in_ready=1 after reset deasserts.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined: adds outputs stat_taken[15:0] and stat_squash[15:0].
  - stat_taken increments on each taken handoff.
  - stat_squash increments on each dropped beat.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- beq, alu_zout=1, pc_plus4=0x100, br_offset=0x3 -> next cycle out_valid=1, taken=1, pc_next=0x10C; flush=1 on handoff; the next input beat is dropped.
- bne, alu_zout=1, pc_plus4=0x200 -> taken=0, pc_next=0x200, link_we=0; back-to-back beats accepted with no bubble while out_ready=1.
- blezal, status_n=1, pc_plus4=0x400, br_offset=0xFFFFFFFE -> taken=1, pc_next=0x3F8, link_we=1, link_addr=31, link_data=0x400.
- brv, alu_sum=0x1237 -> pc_next=0x1234, taken=1. Also: pc_plus4=0xFFFFFFFC, br_offset=0x1, beq taken -> pc_next=0x00000000 (wrap).
- Hold out_ready=0 for 3 cycles while VALID -> outputs stable, in_ready=0; then out_ready=1 -> single handoff.
- Assert rst_n=0 mid-VALID, asynchronously between clock edges -> out_valid=0, taken=0, flush=0 immediately; after release, in_ready=1 and state is IDLE.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution stage behind the ALU: evaluates the branch condition,
// picks the next PC and produces the link write, then hands the result off
// through a one-entry valid/ready register. After a taken handoff, the one
// wrong-path beat that follows is dropped.
// Optional: define BR_STATS_EN to add saturating taken/squash counters.
module branch_resolve #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       br_op,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_zout,
  input  logic             status_n,
  input  logic             status_z,
  input  logic             status_v,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] br_offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pc_next,
  output logic             taken,
  output logic             link_we,
  output logic [4:0]       link_addr,
  output logic [WIDTH-1:0] link_data,
  output logic             flush
`ifdef BR_STATS_EN
  ,
  output logic [15:0]      stat_taken,
  output logic [15:0]      stat_squash
`endif
);

  typedef enum logic [1:0] {StIdle, StValid, StSquash} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_pc_next, r_link_data;
  logic             r_taken, r_link_we;

  logic             w_cond, w_link, w_use_reg;
  logic [WIDTH-1:0] w_rel_target, w_reg_target, w_pc_calc;
  logic             w_load, w_drop;
  logic             w_unused;

  // Register-indirect targets are word aligned, so the low ALU bits are ignored.
  assign w_unused     = ^alu_sum[1:0];
  assign w_rel_target = pc_plus4 + (br_offset << 2);
  assign w_reg_target = {alu_sum[WIDTH-1:2], 2'b00};

  // Decode the opcode into a taken condition, link request and target select.
  always_comb begin
    w_cond    = 1'b0;
    w_link    = 1'b0;
    w_use_reg = 1'b0;
    case (br_op)
      4'b0001: w_cond = alu_zout;
      4'b0010: w_cond = ~alu_zout;
      4'b0011: w_cond = status_n | status_z;
      4'b0100: w_cond = ~status_n & ~status_z;
      4'b0101: w_cond = status_v;
      4'b0110: begin
        w_cond    = 1'b1;
        w_use_reg = 1'b1;
      end
      4'b0111: begin
        w_cond = status_n | status_z;
        w_link = status_n | status_z;
      end
      4'b1000: begin
        w_cond = 1'b1;
        w_link = 1'b1;
      end
      default: ;
    endcase
    w_pc_calc = pc_plus4;
    if (w_cond) w_pc_calc = w_use_reg ? w_reg_target : w_rel_target;
  end

  // Handshake FSM: next state, input acceptance, load and drop decisions.
  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b1;
    w_load    = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_load    = 1'b1;
          w_state_d = StValid;
        end
      end
      StValid: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (r_taken) begin
            // A beat arriving alongside a taken handoff is on the wrong path.
            w_drop    = in_valid;
            w_state_d = StSquash;
          end else if (in_valid) begin
            w_load = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StSquash: begin
        if (in_valid) begin
          w_drop    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and result registers; results only change on an accepted, kept beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pc_next   <= '0;
      r_link_data <= '0;
      r_taken     <= 1'b0;
      r_link_we   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_pc_next   <= w_pc_calc;
        r_link_data <= pc_plus4;
        r_taken     <= w_cond;
        r_link_we   <= w_link;
      end
    end
  end

  assign out_valid = (r_state == StValid);
  assign taken     = out_valid & r_taken;
  assign link_we   = out_valid & r_link_we;
  assign flush     = out_valid & out_ready & r_taken;
  assign pc_next   = r_pc_next;
  assign link_data = r_link_data;
  assign link_addr = 5'(LINK_REG);

`ifdef BR_STATS_EN
  logic [15:0] r_stat_taken, r_stat_squash;

  // Saturating event counters for taken handoffs and dropped beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_taken  <= '0;
      r_stat_squash <= '0;
    end else begin
      if (flush && (r_stat_taken != 16'hFFFF)) r_stat_taken <= r_stat_taken + 16'd1;
      if (w_drop && (r_stat_squash != 16'hFFFF)) r_stat_squash <= r_stat_squash + 16'd1;
    end
  end

  assign stat_taken  = r_stat_taken;
  assign stat_squash = r_stat_squash;
`endif

endmodule
